// File: rtl/alu_shift_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_shift_pipe                                                  |
// | Purpose  : Two-stage pipelined shift/rotate unit (SHR/SHRA/SHL/ROR/ROL)    |
// |            with valid/ready handshakes on both sides.                      |
// | Option   : ALU_SHIFT_PIPE_FLAGS_EN adds zero_flag and carry_out outputs.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module alu_shift_pipe #(
   parameter int DATA_WIDTH = 32,
   parameter int OP_WIDTH   = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [OP_WIDTH-1:0]   op,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] z,
   output logic                  op_err
`ifdef ALU_SHIFT_PIPE_FLAGS_EN
   ,
   output logic                  zero_flag,
   output logic                  carry_out
`endif
);

   localparam int AMT_W = 5;

   localparam logic [OP_WIDTH-1:0] OP_SHR  = OP_WIDTH'(0);
   localparam logic [OP_WIDTH-1:0] OP_SHRA = OP_WIDTH'(1);
   localparam logic [OP_WIDTH-1:0] OP_SHL  = OP_WIDTH'(2);
   localparam logic [OP_WIDTH-1:0] OP_ROR  = OP_WIDTH'(3);
   localparam logic [OP_WIDTH-1:0] OP_ROL  = OP_WIDTH'(4);

   // One binary-weighted sub-stage of the log shifter; illegal opcodes pass through.
   function automatic logic [DATA_WIDTH-1:0] f_step(
      input logic [DATA_WIDTH-1:0] d,
      input logic [OP_WIDTH-1:0]   o,
      input logic                  en,
      input int unsigned           k
   );
      logic [DATA_WIDTH-1:0] r;
      r = d;
      if (en) begin
         case (o)
            OP_SHR:  r = d >> k;
            OP_SHRA: r = $unsigned($signed(d) >>> k);
            OP_SHL:  r = d << k;
            OP_ROR:  r = (d >> k) | (d << (DATA_WIDTH - k));
            OP_ROL:  r = (d << k) | (d >> (DATA_WIDTH - k));
            default: r = d;
         endcase
      end
      return r;
   endfunction

   logic [AMT_W-1:0]      w_amt;
   logic                  w_illegal;
   logic [DATA_WIDTH-1:0] w_p1;
   logic [DATA_WIDTH-1:0] w_p2;
   logic [DATA_WIDTH-1:0] w_p4;
   logic [DATA_WIDTH-1:0] w_q8;
   logic [DATA_WIDTH-1:0] w_q16;
   logic                  w_accept;
   logic                  w_s2_free;
   logic                  w_s2_load;
   logic                  w_unused_b;

   logic                  r_s1_valid;
   logic [OP_WIDTH-1:0]   r_s1_op;
   logic [1:0]            r_s1_amt_hi;
   logic [DATA_WIDTH-1:0] r_s1_data;
   logic                  r_s1_err;

   logic                  r_s2_valid;
   logic [DATA_WIDTH-1:0] r_s2_data;
   logic                  r_s2_err;

   assign w_amt      = b[AMT_W-1:0];
   assign w_unused_b = ^b[DATA_WIDTH-1:AMT_W];
   assign w_illegal  = (op > OP_ROL);

   // Stage 1 covers amount bits [2:0]; stage 2 covers [4:3].
   assign w_p1  = f_step(a,    op, w_amt[0], 1);
   assign w_p2  = f_step(w_p1, op, w_amt[1], 2);
   assign w_p4  = f_step(w_p2, op, w_amt[2], 4);
   assign w_q8  = f_step(r_s1_data, r_s1_op, r_s1_amt_hi[0], 8);
   assign w_q16 = f_step(w_q8,      r_s1_op, r_s1_amt_hi[1], 16);

   assign w_s2_free = !r_s2_valid || out_ready;
   assign w_s2_load = r_s1_valid && w_s2_free;
   assign in_ready  = !r_s1_valid || !r_s2_valid || out_ready;
   assign w_accept  = in_valid && in_ready;

   assign out_valid = r_s2_valid;
   assign z         = r_s2_data;
   assign op_err    = r_s2_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s2_valid <= 1'b0;
      end else begin
         r_s1_valid <= w_accept  || (r_s1_valid && !w_s2_load);
         r_s2_valid <= w_s2_load || (r_s2_valid && !out_ready);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_op     <= '0;
         r_s1_amt_hi <= '0;
         r_s1_data   <= '0;
         r_s1_err    <= 1'b0;
      end else if (w_accept) begin
         r_s1_op     <= op;
         r_s1_amt_hi <= w_amt[4:3];
         r_s1_data   <= w_p4;
         r_s1_err    <= w_illegal;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_data <= '0;
         r_s2_err  <= 1'b0;
      end else if (w_s2_load) begin
         r_s2_data <= w_q16;
         r_s2_err  <= r_s1_err;
      end
   end

`ifdef ALU_SHIFT_PIPE_FLAGS_EN
   logic [AMT_W-1:0] w_idx_r;
   logic [AMT_W-1:0] w_idx_l;
   logic             w_carry;
   logic             r_s1_carry;
   logic             r_s2_carry;
   logic             r_s2_zero;

   // Last bit leaving the operand: a[amt-1] going right, a[32-amt] going left.
   assign w_idx_r = w_amt - 5'd1;
   assign w_idx_l = 5'd0 - w_amt;

   always_comb begin
      w_carry = 1'b0;
      if (w_amt != 5'd0) begin
         case (op)
            OP_SHR, OP_SHRA, OP_ROR: w_carry = a[w_idx_r];
            OP_SHL, OP_ROL:          w_carry = a[w_idx_l];
            default:                 w_carry = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_carry <= 1'b0;
      end else if (w_accept) begin
         r_s1_carry <= w_carry;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_carry <= 1'b0;
         r_s2_zero  <= 1'b0;
      end else if (w_s2_load) begin
         r_s2_carry <= r_s1_carry;
         r_s2_zero  <= (w_q16 == '0);
      end
   end

   assign carry_out = r_s2_carry;
   assign zero_flag = r_s2_zero;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_shift_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_alu_shift_pipe                                               |
// | Purpose  : Self-checking bench for alu_shift_pipe (queue-based model).     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_alu_shift_pipe;

   typedef struct {
      logic [31:0] z;
      logic        err;
      logic        zf;
      logic        cy;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] z;
   logic        op_err;
`ifdef ALU_SHIFT_PIPE_FLAGS_EN
   logic        zero_flag;
   logic        carry_out;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   exp_t        exp_q[$];
   logic [31:0] got_z[$];
   logic        got_err[$];
   int          got_cyc[$];
   logic        got_zf[$];
   logic        got_cy[$];

   logic        stalled = 1'b0;
   logic [31:0] prev_z;
   logic        prev_err;

   alu_shift_pipe #(.DATA_WIDTH(32), .OP_WIDTH(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .z         (z),
      .op_err    (op_err)
`ifdef ALU_SHIFT_PIPE_FLAGS_EN
      ,
      .zero_flag (zero_flag),
      .carry_out (carry_out)
`endif
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb);
      exp_t        e;
      int          n;
      logic [63:0] t;
      n     = int'(vb[4:0]);
      e.err = 1'b0;
      e.cy  = 1'b0;
      case (o)
         3'd0: e.z = va >> n;
         3'd1: e.z = $unsigned($signed(va) >>> n);
         3'd2: e.z = va << n;
         3'd3: begin t = {va, va} >> n; e.z = t[31:0];  end
         3'd4: begin t = {va, va} << n; e.z = t[63:32]; end
         default: begin e.z = va; e.err = 1'b1; end
      endcase
      if (n != 0 && !e.err) begin
         if (o == 3'd2 || o == 3'd4) e.cy = va[32-n];
         else                        e.cy = va[n-1];
      end
      e.zf = (e.z == 32'd0);
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Scoreboard: pops on every output handshake, pushes on every input acceptance.
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         exp_q.delete();
         stalled = 1'b0;
      end else begin
         if (stalled) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_z", z, prev_z);
            chk("hold_err", 32'(op_err), 32'(prev_err));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("spurious_out", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("z", z, e.z);
               chk("op_err", 32'(op_err), 32'(e.err));
`ifdef ALU_SHIFT_PIPE_FLAGS_EN
               chk("zero_flag", 32'(zero_flag), 32'(e.zf));
               chk("carry_out", 32'(carry_out), 32'(e.cy));
               got_zf.push_back(zero_flag);
               got_cy.push_back(carry_out);
`endif
            end
            got_z.push_back(z);
            got_err.push_back(op_err);
            got_cyc.push_back(cyc);
         end
         stalled  = out_valid && !out_ready;
         prev_z   = z;
         prev_err = op_err;
         if (in_valid && in_ready) exp_q.push_back(model(op, a, b));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb);
      logic acc;
      acc      = 1'b0;
      in_valid = 1'b1;
      op       = o;
      a        = va;
      b        = vb;
      for (int t = 0; t < 50 && !acc; t++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      chk("send_accept", 32'(acc), 32'd1);
   endtask

   task automatic drain();
      for (int t = 0; t < 40 && exp_q.size() != 0; t++) @(negedge clk);
      chk("drain_empty", 32'(exp_q.size()), 32'd0);
      tick();
   endtask

   task automatic clear_log();
      got_z.delete();
      got_err.delete();
      got_cyc.delete();
      got_zf.delete();
      got_cy.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc_cnt;
      logic [31:0] amts [7];
      amts = '{32'd0, 32'd1, 32'd7, 32'd8, 32'd16, 32'd31, 32'h25};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      op        = 3'd0;
      a         = 32'd0;
      b         = 32'd0;
      out_ready = 1'b1;
      repeat (3) tick();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_z", z, 32'd0);
      chk("rst_op_err", 32'(op_err), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      rst_n = 1'b1;
      tick();

      // Latency: accepted at edge k, out_valid after edge k+1.
      send(3'd0, 32'h8000_0000, 32'd31);
      chk("lat_early_valid", 32'(out_valid), 32'd0);
      tick();
      chk("lat_valid", 32'(out_valid), 32'd1);
      chk("lat_z", z, 32'h0000_0001);
      chk("lat_err", 32'(op_err), 32'd0);
      drain();
      clear_log();

      // Back-to-back stream
      send(3'd1, 32'h8000_0000, 32'd4);
      chk("b2b_ready", 32'(in_ready), 32'd1);
      send(3'd2, 32'h0000_0001, 32'h25);
      chk("b2b_ready", 32'(in_ready), 32'd1);
      send(3'd4, 32'h8000_0001, 32'd1);
      send(3'd3, 32'h0000_0001, 32'd0);
      drain();
      chk("b2b_count", 32'(got_z.size()), 32'd4);
      if (got_z.size() == 4) begin
         chk("b2b_shra", got_z[0], 32'hF800_0000);
         chk("b2b_shl", got_z[1], 32'h0000_0020);
         chk("b2b_rol", got_z[2], 32'h0000_0003);
         chk("b2b_ror", got_z[3], 32'h0000_0001);
         for (int i = 0; i < 3; i++) chk("b2b_consecutive", 32'(got_cyc[i+1] - got_cyc[i]), 32'd1);
      end
      clear_log();

      // Backpressure: four cycles of offered SHL ops with out_ready low
      out_ready = 1'b0;
      acc_cnt   = 0;
      for (int c = 0; c < 4; c++) begin
         in_valid = 1'b1;
         op       = 3'd2;
         a        = 32'd1;
         b        = 32'(acc_cnt + 1);
         @(negedge clk);
         if (in_ready) acc_cnt++;
         @(posedge clk);
         #1;
      end
      chk("bp_accepted", 32'(acc_cnt), 32'd2);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_z", z, 32'h0000_0002);
      out_ready = 1'b1;
      send(3'd2, 32'd1, 32'd3);
      send(3'd2, 32'd1, 32'd4);
      drain();
      chk("bp_count", 32'(got_z.size()), 32'd4);
      if (got_z.size() == 4) begin
         chk("bp_out0", got_z[0], 32'h2);
         chk("bp_out1", got_z[1], 32'h4);
         chk("bp_out2", got_z[2], 32'h8);
         chk("bp_out3", got_z[3], 32'h10);
      end
      clear_log();

      // Illegal opcode followed by a legal one
      send(3'b110, 32'h1234_5678, 32'd3);
      send(3'd0, 32'h0000_0010, 32'd1);
      drain();
      chk("ill_count", 32'(got_z.size()), 32'd2);
      if (got_z.size() == 2) begin
         chk("ill_z", got_z[0], 32'h1234_5678);
         chk("ill_err", 32'(got_err[0]), 32'd1);
         chk("legal_z", got_z[1], 32'h0000_0008);
         chk("legal_err", 32'(got_err[1]), 32'd0);
      end
      clear_log();

      // Sweep of every opcode across boundary amounts
      for (int o = 0; o < 8; o++)
         for (int i = 0; i < 7; i++) send(3'(o), 32'hA5C3_1E0F, amts[i]);
      drain();
      chk("sweep_count", 32'(got_z.size()), 32'd56);
      if (got_z.size() == 56) begin
         chk("sweep_shra31", got_z[7 + 5], 32'hFFFF_FFFF);
         chk("sweep_ror0", got_z[21], 32'hA5C3_1E0F);
      end
      clear_log();

`ifdef ALU_SHIFT_PIPE_FLAGS_EN
      send(3'd0, 32'h0000_0003, 32'd2);
      send(3'd2, 32'h4000_0000, 32'd1);
      drain();
      chk("flag_count", 32'(got_z.size()), 32'd2);
      if (got_z.size() == 2) begin
         chk("flag_z", got_z[0], 32'd0);
         chk("flag_zero", 32'(got_zf[0]), 32'd1);
         chk("flag_carry_shr", 32'(got_cy[0]), 32'd1);
         chk("flag_carry_shl", 32'(got_cy[1]), 32'd0);
      end
      clear_log();
`endif

      // Asynchronous reset with two operations in flight
      out_ready = 1'b0;
      send(3'd2, 32'd1, 32'd1);
      send(3'd2, 32'd1, 32'd2);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(out_valid), 32'd0);
      chk("arst_in_ready", 32'(in_ready), 32'd1);
      tick();
      tick();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      clear_log();
      for (int c = 0; c < 3; c++) begin
         chk("post_rst_ready", 32'(in_ready), 32'd1);
         chk("post_rst_valid", 32'(out_valid), 32'd0);
         tick();
      end
      send(3'd0, 32'h0000_00F0, 32'd4);
      drain();
      chk("post_rst_count", 32'(got_z.size()), 32'd1);
      if (got_z.size() == 1) chk("post_rst_z", got_z[0], 32'h0000_000F);

      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
